// File: rtl/flash_boot_copier.sv
// Boot-time Wishbone master: copies WORDS 32-bit words from flash to RAM using
// classic single read/write cycles and holds the CPU in reset until the first good copy.
//
// state | meaning
// IDLE  | waiting for autostart or start_i
// RD    | reading one word from flash
// WR    | writing the captured word to RAM
// DONE  | copy finished cleanly, CPU released
// ERR   | copy aborted on bus error or timeout
module flash_boot_copier #(
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h0000_0000,
  parameter int unsigned WORDS     = 16384,
  parameter int unsigned TIMEOUT   = 255,
  parameter bit          AUTOSTART = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        cpu_rst_o
);

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, ERR} state_t;

  localparam logic [15:0] LAST_WORD = 16'(WORDS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] count;
  logic [15:0] tmo_cnt;
  logic        auto_pend;
  logic [15:0] count_nxt;
  logic        abort;

  assign wbm_sel_o = 4'hF;
  assign count_nxt = count + 16'd1;
  // An error beats a simultaneous ack; an ack on the last allowed cycle still counts.
  assign abort = wbm_err_i || (!wbm_ack_i && tmo_cnt == TMO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      count     <= '0;
      tmo_cnt   <= '0;
      auto_pend <= AUTOSTART;
      wbm_adr_o <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_dat_o <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      cpu_rst_o <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i || auto_pend) begin
            auto_pend <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            count     <= '0;
            tmo_cnt   <= '0;
            wbm_adr_o <= SRC_BASE;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            busy_o    <= 1'b1;
            state     <= RD;
          end
        end
        RD, WR: begin
          if (abort) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b1;
            tmo_cnt   <= '0;
            state     <= ERR;
          end else if (wbm_ack_i) begin
            tmo_cnt <= '0;
            if (state == RD) begin
              wbm_dat_o <= wbm_dat_i;
              wbm_adr_o <= DST_BASE + {14'd0, count, 2'b00};
              wbm_we_o  <= 1'b1;
              state     <= WR;
            end else if (count == LAST_WORD) begin
              wbm_cyc_o <= 1'b0;
              wbm_stb_o <= 1'b0;
              wbm_we_o  <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              cpu_rst_o <= 1'b0;
              state     <= DONE;
            end else begin
              count     <= count_nxt;
              wbm_adr_o <= SRC_BASE + {14'd0, count_nxt, 2'b00};
              wbm_we_o  <= 1'b0;
              state     <= RD;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_boot_copier.sv
// Bench for flash_boot_copier: behavioural flash/RAM slave with configurable wait,
// error and no-ack behaviour; expected write streams come from a word-copy model.
module tb_flash_boot_copier;

  localparam logic [31:0] SRC = 32'h0000_0000;
  localparam logic [31:0] DST = 32'h0010_0000;
  localparam int NW  = 4;
  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] adr, dat_o, dat_i;
  logic        cyc, stb, we, ack, err, busy, done, errf, cpu_rst;
  logic [3:0]  sel;

  int tests = 0;
  int fails = 0;

  logic [31:0] flash [0:15];
  int          wait_n = 0;
  bit          err_en = 0;
  logic [31:0] err_adr = 32'h8;
  bit          noack_wr = 0;
  int          wcnt;
  logic [31:0] wlog_adr[$];
  logic [31:0] wlog_dat[$];

  flash_boot_copier #(.SRC_BASE(SRC), .DST_BASE(DST), .WORDS(NW), .TIMEOUT(TMO),
                      .AUTOSTART(1'b1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .wbm_adr_o(adr), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(ack), .wbm_err_i(err),
    .busy_o(busy), .done_o(done), .err_o(errf), .cpu_rst_o(cpu_rst));

  always #5 clk = ~clk;

  // Slave model
  assign err   = cyc && stb && !we && err_en && (adr == err_adr);
  assign ack   = cyc && stb && !err && (wcnt == wait_n) && !(we && noack_wr);
  assign dat_i = flash[adr[5:2]];

  always @(posedge clk or posedge rst) begin
    if (rst) wcnt <= 0;
    else if (cyc && stb && !(ack || err)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(posedge clk) begin
    if (!rst && cyc && stb && we && ack) begin
      wlog_adr.push_back(adr);
      wlog_dat.push_back(dat_o);
    end
  end

  // Bus outputs must hold while a transfer is waiting
  logic        prev_pend = 1'b0;
  logic [31:0] prev_adr, prev_dat;
  logic        prev_we;
  always @(negedge clk) begin
    if (rst) prev_pend <= 1'b0;
    else begin
      if (prev_pend && cyc && stb) begin
        tests++;
        if (adr !== prev_adr || we !== prev_we || dat_o !== prev_dat) begin
          fails++;
          $display("FAIL wait_stable adr=%h we=%b dat=%h required adr=%h we=%b dat=%h",
                   adr, we, dat_o, prev_adr, prev_we, prev_dat);
        end
      end
      prev_pend <= cyc && stb && !ack && !err;
      prev_adr  <= adr;
      prev_we   <= we;
      prev_dat  <= dat_o;
    end
  end

  task automatic fill_flash(bit fixed);
    for (int i = 0; i < 16; i++)
      flash[i] = fixed ? 32'h1122_3344 + 32'h1111_1111 * i : $urandom;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs from the current negedge until the copier is idle with done or err set.
  task automatic run_until_idle(output int busy_cyc, output int wr_cyc, output bit expired,
                                output int done_k, output int cpu_low_k, output bit cpu_hi);
    busy_cyc = 0; wr_cyc = 0; expired = 1; done_k = -1; cpu_low_k = -1; cpu_hi = 0;
    for (int k = 0; k < 600; k++) begin
      if (busy) busy_cyc++;
      if (busy && we) wr_cyc++;
      if (done && done_k < 0) done_k = k;
      if (!cpu_rst && cpu_low_k < 0) cpu_low_k = k;
      if (cpu_rst) cpu_hi = 1;
      if (!busy && (done || errf)) begin
        expired = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({cyc, stb, we} !== 3'b000) begin
      fails++; $display("FAIL reset_bus cyc/stb/we=%b required 000", {cyc, stb, we});
    end
    tests++;
    if (adr !== 32'h0 || dat_o !== 32'h0 || sel !== 4'hF) begin
      fails++; $display("FAIL reset_adr_dat adr=%h dat=%h sel=%h required 0 0 f", adr, dat_o, sel);
    end
    tests++;
    if ({busy, done, errf, cpu_rst} !== 4'b0001) begin
      fails++; $display("FAIL reset_status busy/done/err/cpu_rst=%b required 0001",
                        {busy, done, errf, cpu_rst});
    end
  endtask

  task automatic test_zero_wait_copy();
    int bc, wc, dk, ck; bit exp, hi;
    fill_flash(1);
    wait_n = 0;
    wlog_adr.delete(); wlog_dat.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cyc !== 1'b1 || adr !== SRC || we !== 1'b0) begin
      fails++; $display("FAIL autostart cyc=%b adr=%h we=%b required 1 %h 0", cyc, adr, we, SRC);
    end
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || bc !== 2 * NW) begin
      fails++; $display("FAIL zw_busy busy_cycles=%0d expired=%0d required %0d", bc, exp, 2 * NW);
    end
    tests++;
    if (done !== 1'b1 || errf !== 1'b0 || cpu_rst !== 1'b0 || dk !== ck || dk !== 2 * NW) begin
      fails++; $display("FAIL zw_done done=%b err=%b cpu_rst=%b done_at=%0d cpu_low_at=%0d required 1 0 0 %0d %0d",
                        done, errf, cpu_rst, dk, ck, 2 * NW, 2 * NW);
    end
    tests++;
    if (wlog_adr.size() !== NW) begin
      fails++; $display("FAIL zw_nwrites writes=%0d required %0d", wlog_adr.size(), NW);
    end
    for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL zw_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    int bc, wc, dk, ck; bit exp, hi;
    for (int it = 0; it < 2; it++) begin
      fill_flash(0);
      wait_n = $urandom_range(3, 1);
      wlog_adr.delete(); wlog_dat.delete();
      pulse_start();
      tests++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL ws_start done=%b busy=%b required 0 1", done, busy);
      end
      run_until_idle(bc, wc, exp, dk, ck, hi);
      tests++;
      if (exp || bc !== 2 * NW * (wait_n + 1) || done !== 1'b1) begin
        fails++; $display("FAIL ws_busy waits=%0d busy_cycles=%0d done=%b required %0d 1",
                          wait_n, bc, done, 2 * NW * (wait_n + 1));
      end
      tests++;
      if (wlog_adr.size() !== NW) begin
        fails++; $display("FAIL ws_nwrites writes=%0d required %0d", wlog_adr.size(), NW);
      end
      for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
        tests++;
        if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
          fails++; $display("FAIL ws_write%0d adr=%h dat=%h required adr=%h dat=%h",
                            i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
        end
      end
    end
    wait_n = 0;
  endtask

  task automatic test_read_error();
    int bc, wc, dk, ck; bit exp, hi;
    fill_flash(0);
    #1 rst = 1'b1;
    err_en = 1; err_adr = SRC + 32'h8;
    @(negedge clk);
    wlog_adr.delete(); wlog_dat.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || errf !== 1'b1 || done !== 1'b0 || cyc !== 1'b0 || bc !== 5) begin
      fails++; $display("FAIL rderr_state err=%b done=%b cyc=%b busy_cycles=%0d required 1 0 0 5",
                        errf, done, cyc, bc);
    end
    tests++;
    if (cpu_rst !== 1'b1) begin
      fails++; $display("FAIL rderr_cpu_rst cpu_rst=%b required 1", cpu_rst);
    end
    tests++;
    if (wlog_adr.size() !== 2) begin
      fails++; $display("FAIL rderr_nwrites writes=%0d required 2", wlog_adr.size());
    end
    for (int i = 0; i < 2 && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL rderr_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
    err_en = 0;
    wlog_adr.delete(); wlog_dat.delete();
    @(negedge clk);
    pulse_start();
    tests++;
    if (errf !== 1'b0 || adr !== SRC || busy !== 1'b1) begin
      fails++; $display("FAIL retry_start err=%b adr=%h busy=%b required 0 %h 1", errf, adr, SRC, busy);
    end
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || done !== 1'b1 || cpu_rst !== 1'b0 || wlog_adr.size() !== NW) begin
      fails++; $display("FAIL retry_done done=%b cpu_rst=%b writes=%0d required 1 0 %0d",
                        done, cpu_rst, wlog_adr.size(), NW);
    end
    for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL retry_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int bc, wc, dk, ck; bit exp, hi;
    noack_wr = 1;
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || wc !== TMO || bc !== TMO + 1) begin
      fails++; $display("FAIL tmo_cycles wr_cycles=%0d busy_cycles=%0d required %0d %0d",
                        wc, bc, TMO, TMO + 1);
    end
    tests++;
    if (errf !== 1'b1 || done !== 1'b0 || cyc !== 1'b0 || cpu_rst !== 1'b0 || wlog_adr.size() !== 0) begin
      fails++; $display("FAIL tmo_state err=%b done=%b cyc=%b cpu_rst=%b writes=%0d required 1 0 0 0 0",
                        errf, done, cyc, cpu_rst, wlog_adr.size());
    end
    noack_wr = 0;
  endtask

  task automatic test_reset_mid_copy();
    int bc, wc, dk, ck; bit exp, hi, found;
    fill_flash(0);
    pulse_start();
    found = 0;
    for (int k = 0; k < 50; k++) begin
      if (busy && we && adr == DST + 32'h4) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL midrst_reach word1 write not seen required seen");
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({cyc, stb, we} !== 3'b000 || adr !== 32'h0 || dat_o !== 32'h0) begin
      fails++; $display("FAIL midrst_bus cyc/stb/we=%b adr=%h dat=%h required 000 0 0",
                        {cyc, stb, we}, adr, dat_o);
    end
    tests++;
    if ({busy, done, errf, cpu_rst} !== 4'b0001) begin
      fails++; $display("FAIL midrst_status busy/done/err/cpu_rst=%b required 0001",
                        {busy, done, errf, cpu_rst});
    end
    @(negedge clk);
    wlog_adr.delete(); wlog_dat.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cyc !== 1'b1 || adr !== SRC || we !== 1'b0) begin
      fails++; $display("FAIL midrst_restart cyc=%b adr=%h we=%b required 1 %h 0", cyc, adr, we, SRC);
    end
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || bc !== 2 * NW || done !== 1'b1 || wlog_adr.size() !== NW) begin
      fails++; $display("FAIL midrst_copy busy_cycles=%0d done=%b writes=%0d required %0d 1 %0d",
                        bc, done, wlog_adr.size(), 2 * NW, NW);
    end
    for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL midrst_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
  endtask

  task automatic test_start_ignored_and_repeat();
    int bc, wc, dk, ck; bit exp, hi;
    fill_flash(0);
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1 || we !== 1'b0 || adr !== SRC + 32'h4) begin
      fails++; $display("FAIL ign_in_rd busy=%b we=%b adr=%h required 1 0 %h", busy, we, adr, SRC + 32'h4);
    end
    pulse_start();
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || bc !== 2 * NW - 3 || done !== 1'b1 || wlog_adr.size() !== NW) begin
      fails++; $display("FAIL ign_copy rest_busy=%0d done=%b writes=%0d required %0d 1 %0d",
                        bc, done, wlog_adr.size(), 2 * NW - 3, NW);
    end
    for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL ign_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
    fill_flash(0);
    wlog_adr.delete(); wlog_dat.delete();
    pulse_start();
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b0) begin
      fails++; $display("FAIL rep_start done=%b busy=%b cpu_rst=%b required 0 1 0", done, busy, cpu_rst);
    end
    run_until_idle(bc, wc, exp, dk, ck, hi);
    tests++;
    if (exp || hi || done !== 1'b1 || dk !== 2 * NW || wlog_adr.size() !== NW) begin
      fails++; $display("FAIL rep_copy cpu_rst_seen_high=%0d done=%b done_at=%0d writes=%0d required 0 1 %0d %0d",
                        hi, done, dk, wlog_adr.size(), 2 * NW, NW);
    end
    for (int i = 0; i < NW && i < wlog_adr.size(); i++) begin
      tests++;
      if (wlog_adr[i] !== DST + 32'(4 * i) || wlog_dat[i] !== flash[i]) begin
        fails++; $display("FAIL rep_write%0d adr=%h dat=%h required adr=%h dat=%h",
                          i, wlog_adr[i], wlog_dat[i], DST + 32'(4 * i), flash[i]);
      end
    end
  endtask

  initial begin
    fill_flash(1);
    test_reset();
    test_zero_wait_copy();
    test_wait_states();
    test_read_error();
    test_timeout();
    test_reset_mid_copy();
    test_start_ignored_and_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/flash_boot_copier.md
# flash_boot_copier

Wishbone master that copies a boot image, one 32-bit word at a time, from the flash memory slave into main RAM. It issues classic single read/write cycles, holds the CPU in reset until the copy completes, and reports completion or bus error. It sits on the system Wishbone bus as an initiator alongside the CPU, ahead of it in arbitration during boot.

## Interface
- SRC_BASE, 32'h0000_0000, flash byte address of first source word (word aligned)
- DST_BASE, 32'h0000_0000, RAM byte address of first destination word (word aligned)
- WORDS, 16384, number of 32-bit words to copy (1..65535)
- TIMEOUT, 255, max cycles waiting for ack/err per transfer (1..65535)
- AUTOSTART, 1, 1 = start copy on first clock after reset release
- wb_clk_i  in  1  system clock, all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; starts a copy when in IDLE, DONE or ERR
- wbm_adr_o  out  32  byte address, bits [1:0] always 0
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  1 = write
- wbm_sel_o  out  4  always 4'hF
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data, sampled on read ack
- wbm_ack_i  in  1  slave acknowledge
- wbm_err_i  in  1  slave error
- busy_o  out  1  copy in progress
- done_o  out  1  copy completed without error (sticky)
- err_o  out  1  copy aborted: bus error or timeout (sticky)
- cpu_rst_o  out  1  CPU reset request; high until first successful copy

## Operation
- States: IDLE, RD, WR, DONE, ERR. All outputs registered.
- Reset: state IDLE; wbm_cyc_o/stb_o/we_o = 0, adr_o = 0, dat_o = 0, sel_o = 4'hF; busy_o/done_o/err_o = 0; cpu_rst_o = 1; word counter = 0; timeout counter = 0.
- Start (AUTOSTART first cycle after reset, or start_i in IDLE/DONE/ERR): clear done_o/err_o, counter = 0, enter RD with adr_o = SRC_BASE. start_i in RD/WR ignored.
- RD: cyc=stb=1, we=0, adr = SRC_BASE + 4*count. On ack: latch wbm_dat_i into dat_o, enter WR with adr = DST_BASE + 4*count, we=1.
- WR: cyc=stb=1, we=1. On ack: if count == WORDS-1 enter DONE, else count+1, enter RD.
- err_i asserted (with or without ack) in RD/WR: enter ERR; err wins over ack in the same cycle.
- Timeout counter resets on every state entry; reaching TIMEOUT cycles in RD/WR with no ack/err -> ERR.
- DONE: cyc/stb/we = 0, busy_o = 0, done_o = 1, cpu_rst_o = 0 (stays 0 until wb_rst_i, even across later copies).
- ERR: cyc/stb/we = 0, busy_o = 0, err_o = 1, cpu_rst_o unchanged.
- busy_o = 1 exactly in RD and WR.
- Address arithmetic modulo 2^32; count is 16 bits; no wrap beyond WORDS.
- wb_rst_i mid-copy: bus released immediately (asynchronous), all outputs to reset values.

## Timing
- Slave acks combinationally (same cycle stb seen): each word costs 2 cycles (RD 1, WR 1); cyc_o held high continuously between transfers, adr/we change on the clock after ack.
- Copy of N words with zero-wait slave: busy_o high 2N cycles; done_o rises the cycle after final write ack.
- Wait states: outputs held stable until ack/err.
- AUTOSTART: cyc_o rises on the first rising edge after wb_rst_i falls.
- Read data captured on the edge where ack_i is high in RD; dat_o valid throughout WR.

## Test plan
- Zero-wait copy, SRC_BASE=0, DST_BASE=32'h0010_0000, WORDS=4, flash words 11223344..44556677 -> RAM holds same 4 words, busy_o 8 cycles, done_o=1, cpu_rst_o falls with done_o.
- Slave with 3 wait states on every ack, WORDS=2 -> adr/we/dat stable during waits, busy_o 16 cycles, correct data.
- err_i on read of word 2 (adr 8) -> ERR, cyc_o=0 next cycle, err_o=1, cpu_rst_o stays 1, words 0-1 written only; start_i then retries from word 0.
- No ack on write, TIMEOUT=5 -> ERR after 5 cycles in WR, err_o=1.
- wb_rst_i asserted mid-copy (word 1 in WR) -> cyc_o/stb_o drop asynchronously, all outputs to reset values; copy restarts from word 0 after release.
- start_i pulse during RD -> ignored; after DONE, start_i repeats copy with done_o cleared until finish, cpu_rst_o remains 0.
